irq_ctrl: RTL and testbench

- Parametrised interrupt controller between peripheral interrupt sources and the picorv32 IRQ/EOI interface. Generalises the hard-wired 16-line irq/eoi pass-through to NUM_IRQ channels.
- Each channel has an input synchroniser, per-channel edge or level mode, a pending latch, an enable mask and EOI acknowledge back to the source.
- Registers are accessed through a memory-mapped slave on the native picorv32 mem bus, decoded at BASE_ADDR.

---
 rtl/irq_ctrl_pkg.sv | 30 +++
 rtl/irq_sync_edge.sv | 31 +++
 rtl/irq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, bus FSM states and the claim
// priority helper shared by the interrupt controller files.
package irq_ctrl_pkg;

  localparam int MAX_IRQ = 32;

  localparam logic [4:0] OFF_PENDING = 5'h00;
  localparam logic [4:0] OFF_ENABLE  = 5'h04;
  localparam logic [4:0] OFF_MODE    = 5'h08;
  localparam logic [4:0] OFF_INFO    = 5'h0C;
  localparam logic [4:0] OFF_CLAIM   = 5'h10;

  typedef enum logic {
    IDLE,
    ACK
  } bus_state_t;

  // Returns {valid, id} of the lowest set bit, or 0 when none is set.
  function automatic logic [5:0] lowest_set(
    input logic [MAX_IRQ-1:0] v
  );
    logic [5:0] r;
    r = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: one channel's input synchroniser chain plus a
// rising-edge detect on the synchronised level.
module irq_sync_edge
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: NUM_IRQ-channel interrupt controller on the picorv32 mem bus.
// Define IRQ_CTRL_PRIO_EN for the CLAIM register and one-hot cpu_irq.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ     = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] eoi_out,
  output logic [31:0]        cpu_irq,
  input  logic [31:0]        cpu_eoi,
  input  logic               mem_valid,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready
);

  logic [NUM_IRQ-1:0] w_lvl;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_eoi_rise;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_wmask;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_pend_nx;
  logic [31:0]        w_bmask;
  logic [31:0]        w_rd;
  logic [4:0]         w_off;
  logic [5:0]         w_claim;
  logic               w_acc;
  logic               w_wr;
  logic               w_unused;

  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_en;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_eoi_prev;
  logic [NUM_IRQ-1:0] r_eoi_out;
  logic [NUM_IRQ-1:0] r_cpu_irq;
  bus_state_t         r_state;
  logic               r_ready;
  logic [31:0]        r_rdata;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_irq  (irq_in[g]),
      .o_level(w_lvl[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_off   = mem_addr[4:0];
  assign w_acc   = (r_state == IDLE) && mem_valid &&
                   (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign w_wr    = w_acc && (mem_wstrb != 4'b0000);
  assign w_bmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                    {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign w_wmask = w_bmask[NUM_IRQ-1:0];
  assign w_wdata = mem_wdata[NUM_IRQ-1:0] & w_wmask;
  assign w_w1c   = (w_wr && w_off == OFF_PENDING) ? w_wdata : '0;

  assign w_eoi_rise = cpu_eoi[NUM_IRQ-1:0] & ~r_eoi_prev;

  // Edge channels: a new edge beats any clear in the same cycle.
  assign w_pend_nx =
    (r_mode & ((r_pend & ~(w_w1c | w_eoi_rise)) | w_rise)) |
    (~r_mode & w_lvl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_en       <= '0;
      r_mode     <= '0;
      r_eoi_prev <= '0;
      r_eoi_out  <= '0;
    end else begin
      r_pend     <= w_pend_nx;
      r_eoi_prev <= cpu_eoi[NUM_IRQ-1:0];
      r_eoi_out  <= w_eoi_rise;
      if (w_wr && w_off == OFF_ENABLE)
        r_en <= (r_en & ~w_wmask) | w_wdata;
      if (w_wr && w_off == OFF_MODE)
        r_mode <= (r_mode & ~w_wmask) | w_wdata;
    end
  end

`ifdef IRQ_CTRL_PRIO_EN
  logic [NUM_IRQ-1:0] r_pe;

  assign w_claim = lowest_set(MAX_IRQ'(r_pe));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pe      <= '0;
      r_cpu_irq <= '0;
    end else begin
      r_pe      <= r_pend & r_en;
      r_cpu_irq <= w_claim[5] ? (NUM_IRQ'(1) << w_claim[4:0]) : '0;
    end
  end
`else
  assign w_claim = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cpu_irq <= '0;
    else     r_cpu_irq <= r_pend & r_en;
  end
`endif

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_off == OFF_PENDING: w_rd = 32'(r_pend);
      w_off == OFF_ENABLE:  w_rd = 32'(r_en);
      w_off == OFF_MODE:    w_rd = 32'(r_mode);
      w_off == OFF_INFO:    w_rd = {26'b0, 6'(NUM_IRQ)};
      w_off == OFF_CLAIM:
        w_rd = w_claim[5] ? {1'b1, 26'b0, w_claim[4:0]} : '0;
      default:              w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_state <= ACK;
            r_ready <= 1'b1;
            r_rdata <= w_wr ? '0 : w_rd;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign eoi_out   = r_eoi_out;
  assign cpu_irq   = 32'(r_cpu_irq);
  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;

  assign w_unused = ^{cpu_eoi, mem_wdata, w_bmask};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomised scoreboard bench for irq_ctrl against a
// history-queue reference model of the channel and register rules.
module tb_irq_ctrl;

  localparam int          N    = 16;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in;
  logic [N-1:0] eoi_out;
  logic [31:0]  cpu_irq;
  logic [31:0]  cpu_eoi;
  logic         mem_valid;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_rdata;
  logic         mem_ready;

  irq_ctrl #(
    .NUM_IRQ    (N),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .eoi_out  (eoi_out),
    .cpu_irq  (cpu_irq),
    .cpu_eoi  (cpu_eoi),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {is_read, expected rdata}
  logic [32:0] exp_q[$];

  // Model: irq_in sampled at each edge, newest first.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pend, m_en, m_mode;
  logic [N-1:0] m_cpu, m_eoi_out, m_eoi_last, m_pe;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return 32'h8000_0000 | 32'(i);
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] off);
    case (off)
      5'h00: return 32'(m_pend);
      5'h04: return 32'(m_en);
      5'h08: return 32'(m_mode);
      5'h0C: return 32'(N);
`ifdef IRQ_CTRL_PRIO_EN
      5'h10: return lowest(m_pe);
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0;
    m_cpu = '0; m_eoi_out = '0; m_eoi_last = '0; m_pe = '0;
    hist.delete();
    repeat (S + 2) hist.push_back('0);
  endtask

  // One clock: advance the model by the rules, then check at negedge.
  task automatic tick(input bit acc);
    logic [N-1:0] lvl, rise, erise, w1c, wd, bm, nx, ne, nm;
    logic [31:0]  bm32, l;
    @(posedge clk);
    hist.push_front(irq_in);
    void'(hist.pop_back());
    lvl   = hist[S];
    rise  = hist[S] & ~hist[S+1];
    erise = cpu_eoi[N-1:0] & ~m_eoi_last;
    bm32  = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
             {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    bm    = bm32[N-1:0];
    wd    = mem_wdata[N-1:0] & bm;
    w1c   = '0;
    ne    = m_en;
    nm    = m_mode;
    if (acc) begin
      exp_q.push_back({mem_wstrb == 4'h0, model_read(mem_addr[4:0])});
      if (mem_wstrb != 4'h0) begin
        case (mem_addr[4:0])
          5'h00: w1c = wd;
          5'h04: ne  = (m_en & ~bm) | wd;
          5'h08: nm  = (m_mode & ~bm) | wd;
          default: ;
        endcase
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i])            nx[i] = lvl[i];
      else if (rise[i])          nx[i] = 1'b1;
      else if (w1c[i] | erise[i]) nx[i] = 1'b0;
      else                       nx[i] = m_pend[i];
    end
`ifdef IRQ_CTRL_PRIO_EN
    l     = lowest(m_pe);
    m_cpu = l[31] ? (N'(1) << l[4:0]) : '0;
    m_pe  = m_pend & m_en;
`else
    l     = '0;
    m_cpu = m_pend & m_en;
`endif
    m_eoi_out  = erise;
    m_eoi_last = cpu_eoi[N-1:0];
    m_pend     = nx;
    m_en       = ne;
    m_mode     = nm;
    @(negedge clk);
    check("cpu_irq", cpu_irq, 32'(m_cpu));
    check("eoi_out", 32'(eoi_out), 32'(m_eoi_out));
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
    if (a[31:5] == BASE[31:5]) begin
      tick(1'b1);
      check("rdy_lat", 32'(mem_ready), 32'd1);
      // Sometimes keep valid high across the ack cycle.
      if ($urandom_range(0, 1) == 0) mem_valid = 1'b0;
      tick(1'b0);
    end else begin
      repeat (3) begin
        tick(1'b0);
        check("rdy_oow", 32'(mem_ready), 32'd0);
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (!rst) begin
      if (mem_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rdy_unexp: got ready=1 want none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          n_cmp--;
          if (e[32]) check("rdata", mem_rdata, e[31:0]);
          else       n_cmp++;
        end
      end else begin
        check("rdata_idle", mem_rdata, 32'h0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    irq_in    = '1;
    cpu_eoi   = '1;
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h0C;
    mem_wdata = '0;
    mem_wstrb = 4'h0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("rst_cpu_irq", cpu_irq, 32'h0);
      check("rst_eoi", 32'(eoi_out), 32'h0);
      check("rst_rdy", 32'(mem_ready), 32'h0);
      check("rst_rdata", mem_rdata, 32'h0);
    end
    irq_in    = '0;
    cpu_eoi   = '0;
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    bus(BASE + 32'h0C, 32'h0, 4'h0);
    bus(BASE + 32'h10, 32'h0, 4'h0);

    // Edge channel 0: pulse, latency, EOI clear and ack pulse.
    bus(BASE + 32'h08, 32'h0000_FFFF, 4'hF);
    bus(BASE + 32'h04, 32'h0000_0001, 4'hF);
    irq_in[0] = 1'b1;
    tick(1'b0);
    irq_in[0] = 1'b0;
    repeat (S + 3) tick(1'b0);
    bus(BASE, 32'h0, 4'h0);
    cpu_eoi[0] = 1'b1;
    tick(1'b0);
    tick(1'b0);
    cpu_eoi[0] = 1'b0;
    repeat (2) tick(1'b0);
    bus(BASE, 32'h0, 4'h0);

    // Level channel 3 held high through a W1C, then dropped.
    bus(BASE + 32'h08, 32'h0000_FFF7, 4'hF);
    bus(BASE + 32'h04, 32'h0000_0008, 4'hF);
    irq_in[3] = 1'b1;
    repeat (S + 3) tick(1'b0);
    bus(BASE, 32'h0000_0008, 4'hF);
    bus(BASE, 32'h0, 4'h0);
    irq_in[3] = 1'b0;
    repeat (S + 3) tick(1'b0);

    // Edge channel 5 masked, then enabled.
    bus(BASE + 32'h08, 32'h0000_FFFF, 4'hF);
    bus(BASE + 32'h04, 32'h0, 4'hF);
    irq_in[5] = 1'b1;
    tick(1'b0);
    irq_in[5] = 1'b0;
    repeat (S + 3) tick(1'b0);
    bus(BASE, 32'h0, 4'h0);
    bus(BASE + 32'h04, 32'h0000_0020, 4'h1);
    repeat (3) tick(1'b0);

    // Channel 2 edge lands in the same cycle as its W1C.
    irq_in[2] = 1'b1;
    repeat (S) tick(1'b0);
    bus(BASE, 32'h0000_0004, 4'hF);
    bus(BASE, 32'h0, 4'h0);
    irq_in[2] = 1'b0;

    // Byte-lane write: only lane 1 of MODE changes.
    bus(BASE + 32'h08, 32'h0000_0000, 4'h2);
    bus(BASE + 32'h08, 32'h0, 4'h0);

`ifdef IRQ_CTRL_PRIO_EN
    bus(BASE + 32'h08, 32'h0000_FFFF, 4'hF);
    repeat (S + 3) tick(1'b0);
    bus(BASE, 32'h0000_FFFF, 4'hF);
    bus(BASE + 32'h04, 32'h0000_FFFF, 4'hF);
    irq_in[7] = 1'b1;
    irq_in[4] = 1'b1;
    tick(1'b0);
    irq_in = '0;
    repeat (S + 4) tick(1'b0);
    bus(BASE + 32'h10, 32'h0, 4'h0);
    cpu_eoi[4] = 1'b1;
    tick(1'b0);
    cpu_eoi = '0;
    repeat (3) tick(1'b0);
    bus(BASE + 32'h10, 32'h0, 4'h0);
`endif

    for (int it = 0; it < 400; it++) begin
      automatic int r = $urandom_range(0, 9);
      automatic int k = $urandom_range(0, N - 1);
      automatic logic [31:0] off = 32'(4 * $urandom_range(0, 7));
      cpu_eoi = '0;
      if (r <= 2)      irq_in[k] = ~irq_in[k];
      else if (r == 3) cpu_eoi[k] = 1'b1;
      if (r == 8)      bus(BASE + 32'h40 + off, $urandom, 4'h0);
      else if (r >= 6) bus(BASE + off, $urandom, 4'($urandom));
      else             tick(1'b0);
    end
    cpu_eoi = '0;

    // Reset during an accepted access: no ready, state lost.
    bus(BASE + 32'h04, 32'h0000_00FF, 4'hF);
    mem_addr  = BASE + 32'h0C;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    mem_valid = 1'b0;
    irq_in    = '0;
    @(negedge clk);
    check("rst_mid_rdy", 32'(mem_ready), 32'h0);
    check("rst_mid_irq", cpu_irq, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus(BASE + 32'h04, 32'h0, 4'h0);
    bus(BASE + 32'h0C, 32'h0, 4'h0);
    tick(1'b0);

    check("q_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
